serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets operand/result width in bits (legal 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new addition; honoured only in IDLE.
REQ-005 a  input  WIDTH  operand A; sampled on accepted start.
REQ-006 b  input  WIDTH  operand B; sampled on accepted start.
REQ-007 cin  input  1  carry-in; sampled on accepted start.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 sum  output  WIDTH  result, LSB-first assembled.
REQ-011 cout  output  1  final carry-out.

Function
REQ-012 The block SHALL time-share one 1-bit full adder over WIDTH cycles, bit 0 first.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when bit counter = WIDTH-1; DONE->IDLE unconditionally after one cycle.
REQ-014 On accepted start: a, b latched into shift registers, cin into carry flop, bit counter cleared, sum cleared.
REQ-015 Each RUN cycle: adder inputs = LSBs of A/B shift registers and carry flop; adder sum shifted into sum MSB, sum register shifted right; carry flop <- adder carry; A/B shifted right; counter +1.
REQ-016 Latency: start sampled at edge N -> done high during cycle after edge N+WIDTH; busy high from edge N through edge N+WIDTH.
REQ-017 busy SHALL be high in RUN only; done SHALL be high in DONE only.
REQ-018 cout SHALL equal carry flop value after final RUN cycle; cout and sum SHALL hold stable from DONE until next accepted start.
REQ-019 start while in RUN or DONE SHALL be ignored (no queuing); re-assertion in IDLE required.
REQ-020 Changes on a, b, cin after acceptance SHALL not affect the result.
REQ-021 Counter SHALL be $clog2(WIDTH) bits and SHALL not wrap during RUN; exit on WIDTH-1 compare.
REQ-022 Result SHALL equal {cout,sum} = a + b + cin modulo 2^(WIDTH+1).

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, shift registers=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-025 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default WIDTH constant.
REQ-027 The 1-bit full adder SHALL be a separate combinational sub-module, full_adder_bit (a, b, cin -> sum, cout), instantiated once.
REQ-028 Control FSM, counter and shift datapath SHALL reside in serial_adder_ctrl.

Verification (WIDTH=8)
REQ-029 a=8'h00, b=8'h00, cin=0, start -> done 8 cycles later, sum=8'h00, cout=0.
REQ-030 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; busy high exactly 8 cycles.
REQ-031 a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; a/b toggled during RUN leave result unchanged.
REQ-032 start pulsed at RUN cycle 3 and during DONE -> single done pulse, result of first operands only, FSM in IDLE afterwards.
REQ-033 rst_n low at RUN cycle 4 -> outputs zero immediately, no done; subsequent a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0.
REQ-034 Random sweep, 1000 operand triples, back-to-back starts -> {cout,sum} matches a+b+cin every time.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial adder controller.
//   - DEFAULT_WIDTH : default operand/result width in bits.
//   - state_e       : control FSM encoding (IDLE=00, RUN=01, DONE=10).
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage : serial_adder_ctrl_pkg

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
//   Purely combinational 1-bit full adder; the serial adder reuses one
//   instance of it for every bit position.
//   Ports:
//     a, b  in  1  addend bits
//     cin   in  1  carry in
//     sum   out 1  a ^ b ^ cin
//     cout  out 1  majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder_bit

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder: one full adder is time-shared over WIDTH clock cycles,
//   bit 0 first, producing {cout,sum} = a + b + cin.
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     start      in   1      request an addition (honoured only in IDLE)
//     a, b       in   WIDTH  operands, captured when start is accepted
//     cin        in   1      carry in, captured when start is accepted
//     busy       out  1      high while the FSM is in RUN
//     done       out  1      one-cycle pulse (FSM in DONE), result valid
//     sum        out  WIDTH  result, assembled LSB first
//     cout       out  1      final carry out
//     dbg_state  out  2      current FSM state (state_e encoding)
//
//   Handshake: start is a request sampled on a rising edge; it is accepted
//   only when the FSM is IDLE and is otherwise dropped (no queuing). An
//   accepted start produces exactly one done pulse WIDTH+1 cycles later
//   unless reset intervenes. sum/cout hold from done until the next accepted
//   start.
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  assign accept   = (state_q == S_IDLE) && start;
  assign last_bit = (state_q == S_RUN) && (cnt_q == LAST_BIT);

  // Single shared 1-bit adder fed from the operand LSBs and the carry flop.
  full_adder_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift datapath and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      sum_sr  <= '0;
      carry_q <= cin;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
      sum_sr  <= {fa_sum, sum_sr[WIDTH-1:1]};
      carry_q <= fa_cout;
      if (last_bit) begin
        // Capture the final carry separately so cout is only ever a
        // finished result; the counter stops here instead of wrapping.
        cout_q <= fa_cout;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sum       = sum_sr;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule : serial_adder_ctrl
